// File: rtl/tt_um_acc_pkg.sv
// Shared constants and FSM state type for the sum accumulator.
`timescale 1ns/1ps
package tt_um_acc_pkg;

  localparam int unsigned WindowDefault = 16;
  localparam int unsigned TotalWDefault = 12;
  // Width of one sample, {Cout, Sum}
  localparam int unsigned SampleW       = 4;
  localparam int unsigned CountW        = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StEmit
  } acc_state_e;

endpackage

// File: rtl/tt_um_acc_out_slot.sv
// Single-entry output register with valid/ready handshake.
// A load takes priority over the drain of the previous entry.
`timescale 1ns/1ps
module tt_um_acc_out_slot
  import tt_um_acc_pkg::*;
#(
  parameter int unsigned TOTAL_W = TotalWDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TOTAL_W-1:0] load_total,
  input  logic [CountW-1:0]  load_count,
  input  logic               out_ready,
  output logic [TOTAL_W-1:0] out_total,
  output logic [CountW-1:0]  out_count,
  output logic               out_valid
);

  logic [TOTAL_W-1:0] total_q;
  logic [CountW-1:0]  count_q;
  logic               valid_q;

  // Load a new result, or retire the held one once the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      total_q <= load_total;
      count_q <= load_count;
      valid_q <= 1'b1;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_total = total_q;
  assign out_count = count_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/tt_um_sum_accumulator.sv
// Windowed accumulator of 4-bit {Cout, Sum} samples from an upstream adder.
// Emits the window total and sample count after WINDOW samples or on flush.
// Optional macro ACC_SATURATE_EN: clamp the running total instead of wrapping.
`timescale 1ns/1ps
module tt_um_sum_accumulator
  import tt_um_acc_pkg::*;
#(
  parameter int unsigned WINDOW  = WindowDefault,
  parameter int unsigned TOTAL_W = TotalWDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         Sum,
  input  logic               Cout,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [TOTAL_W-1:0] out_total,
  output logic [CountW-1:0]  out_count,
  output logic               out_valid,
  input  logic               out_ready
);

  acc_state_e         state_q, state_d;
  logic [TOTAL_W-1:0] acc_q, acc_d;
  logic [CountW-1:0]  cnt_q, cnt_d;

  logic [SampleW-1:0] sample;
  logic [TOTAL_W-1:0] acc_add;
  logic               accept;
  logic               last;
  logic               load;

  assign sample   = {Cout, Sum};
  assign in_ready = (state_q != StEmit);
  assign accept   = in_valid && in_ready;
  // This acceptance completes the window
  assign last     = (cnt_q == CountW'(WINDOW - 1));

`ifdef ACC_SATURATE_EN
  localparam int unsigned SumW = TOTAL_W + 1;
  logic [SumW-1:0] sum_wide;

  // Add with one guard bit and clamp on overflow
  always_comb begin
    sum_wide = {1'b0, acc_q} + SumW'(sample);
    acc_add  = sum_wide[TOTAL_W] ? '1 : sum_wide[TOTAL_W-1:0];
  end
`else
  // Modulo-2^TOTAL_W add
  always_comb begin
    acc_add = acc_q + TOTAL_W'(sample);
  end
`endif

  // Next-state, accumulator update and output-slot load decision
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // flush has no effect here; only a sample starts a window
        if (accept) begin
          acc_d   = acc_add;
          cnt_d   = cnt_q + CountW'(1);
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          acc_d = acc_add;
          cnt_d = cnt_q + CountW'(1);
        end
        // A sample on the flush edge is already folded into acc_d above
        if ((accept && last) || flush) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (!out_valid || out_ready) begin
          load    = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  tt_um_acc_out_slot #(
    .TOTAL_W (TOTAL_W)
  ) u_out_slot (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_total (acc_q),
    .load_count (cnt_q),
    .out_ready  (out_ready),
    .out_total  (out_total),
    .out_count  (out_count),
    .out_valid  (out_valid)
  );

endmodule

// File: tb/tb_tt_um_sum_accumulator.sv
// Directed bench for tt_um_sum_accumulator with a result scoreboard.
// Second instance uses TOTAL_W=4 to exercise wrap/saturation.
`timescale 1ns/1ps
module tb_tt_um_sum_accumulator;

  localparam int unsigned Window = 16;
  localparam int unsigned TotW   = 12;

  typedef struct packed {
    logic [TotW-1:0] total;
    logic [7:0]      count;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      sum;
  logic            cout;
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [TotW-1:0] out_total;
  logic [7:0]      out_count;
  logic            out_valid;
  logic            out_ready;

  logic [3:0]      s4;
  logic            v4, f4, r4, ir4, ov4;
  logic [3:0]      ot4;
  logic [7:0]      oc4;

  exp_t            exp_q[$];
  exp_t            mon_e;
  int              checks = 0;
  int              errors = 0;
  logic [TotW-1:0] m_acc;
  int              m_cnt;

  always #5 clk = ~clk;

  tt_um_sum_accumulator #(
    .WINDOW  (Window),
    .TOTAL_W (TotW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Sum       (sum),
    .Cout      (cout),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_total (out_total),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  tt_um_sum_accumulator #(
    .WINDOW  (16),
    .TOTAL_W (4)
  ) dut4 (
    .clk       (clk),
    .rst       (rst),
    .Sum       (s4[2:0]),
    .Cout      (s4[3]),
    .in_valid  (v4),
    .in_ready  (ir4),
    .flush     (f4),
    .out_total (ot4),
    .out_count (oc4),
    .out_valid (ov4),
    .out_ready (r4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Scoreboard: a transfer happens on the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_emit", 32'(out_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_total", 32'(out_total), 32'(mon_e.total));
        chk("sb_count", 32'(out_count), 32'(mon_e.count));
      end
    end
  end

  task automatic push(input logic [3:0] v, input logic with_flush);
    int n;
    int prior;
    n        = 0;
    in_valid = 1'b1;
    {cout, sum} = v;
    flush    = with_flush;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    prior    = m_cnt;
    m_acc    = m_acc + TotW'(v);
    m_cnt++;
    if (m_cnt == Window || (with_flush && prior > 0)) begin
      exp_q.push_back('{total: m_acc, count: 8'(m_cnt)});
      m_acc = '0;
      m_cnt = 0;
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (m_cnt > 0) begin
      exp_q.push_back('{total: m_acc, count: 8'(m_cnt)});
      m_acc = '0;
      m_cnt = 0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_total"}, 32'(out_total), 32'd0);
    chk({tag, "_out_count"}, 32'(out_count), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [3:0] exp4;
    rst = 1'b1; sum = '0; cout = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    s4 = '0; v4 = 1'b0; f4 = 1'b0; r4 = 1'b1;
    m_acc = '0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_chk("reset");
    chk("reset_dut4_valid", 32'(ov4), 32'd0);
    rst = 1'b0;

    // Full window of 5s: 80/16, one cycle after final acceptance
    for (int i = 0; i < 16; i++) push(4'd5, 1'b0);
    chk("lat_valid_low", 32'(out_valid), 32'd0);
    chk("emit_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_valid_high", 32'(out_valid), 32'd1);
    chk("win_total", 32'(out_total), 32'd80);
    chk("win_count", 32'(out_count), 32'd16);
    wait_drain();

    // Partial window flushed: 45/3
    for (int i = 0; i < 3; i++) push(4'd15, 1'b0);
    do_flush();
    wait_drain();
    // Flush together with a sample: sample included, 18/3
    push(4'd7, 1'b0);
    push(4'd7, 1'b0);
    push(4'd4, 1'b1);
    wait_drain();
    // Flush in IDLE does nothing
    do_flush();
    repeat (5) @(posedge clk);
    #1;
    chk("idle_flush_no_emit", 32'(out_valid), 32'd0);

    // Backpressure across two windows
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(4'd2, 1'b0);
    for (int i = 0; i < 16; i++) push(4'd3, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_total", 32'(out_total), 32'd32);
    chk("stall_count", 32'(out_count), 32'd16);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_total_held", 32'(out_total), 32'd32);
    out_ready = 1'b1;
    wait_drain();

    // Reset mid-window discards the partial result
    for (int i = 0; i < 7; i++) push(4'd9, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_acc = '0; m_cnt = 0;
    reset_chk("rst_mid");
    for (int i = 0; i < 16; i++) push(4'd1, 1'b0);
    wait_drain();

    // Reset while one result is held and another is stalled in EMIT
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(4'd4, 1'b0);
    for (int i = 0; i < 16; i++) push(4'd4, 1'b0);
    repeat (3) @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_acc = '0; m_cnt = 0;
    reset_chk("rst_emit");
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_emit_no_emit", 32'(out_valid), 32'd0);

    // TOTAL_W=4: 15 + 3 wraps to 2, or clamps at 15
`ifdef ACC_SATURATE_EN
    exp4 = 4'd15;
`else
    exp4 = 4'd2;
`endif
    v4 = 1'b1; s4 = 4'd15;
    @(posedge clk);
    #1;
    s4 = 4'd3;
    @(posedge clk);
    #1;
    v4 = 1'b0; f4 = 1'b1;
    @(posedge clk);
    #1;
    f4 = 1'b0;
    n = 0;
    while (!ov4 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("w4_valid", 32'(ov4), 32'd1);
    chk("w4_total", 32'(ot4), 32'(exp4));
    chk("w4_count", 32'(oc4), 32'd2);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
